multi_clk_div: RTL and testbench

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/multi_clk_div_pkg.sv | 21 ++
 rtl/multi_clk_div_channel.sv | 77 +++++++
 rtl/multi_clk_div.sv | 50 +++++
 tb/tb_multi_clk_div.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clk_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : multi_clk_div_pkg
// Brief   : Shared defaults, half-period type and helpers for multi_clk_div.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package multi_clk_div_pkg;

  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned DEFAULT_HALF_DEF = 25000;

  // Half-period in clk cycles at the default counter width
  typedef logic [CNT_W_DEF-1:0] half_t;

  // Width of the channel-select field; a single channel still needs one bit
  function automatic int unsigned ch_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : multi_clk_div_pkg
`default_nettype wire

// File: rtl/multi_clk_div_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : clk_div_channel
// Brief   : One divider channel: shadow/active half-period, up-counter,
//           registered square wave and rising-edge tick.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module clk_div_channel #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 25000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_half,
  output logic             o_out_clk,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] C_RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_tick;

  // A write landing in the same cycle as a reload must be seen by the reload,
  // so every load of r_active takes the post-write shadow value.
  logic [CNT_W-1:0] w_shadow_nxt;
  logic             w_hit;

  assign w_shadow_nxt = i_cfg_we ? i_cfg_half : r_shadow;
  // Greater-or-equal so that active values of 0 and 1 both end every cycle
  // and a shrunken active value can never leave the counter running away.
  assign w_hit        = (r_cnt >= r_active);

  // Shadow register: captures every write addressed to this channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= C_RST_HALF;
    end else begin
      r_shadow <= w_shadow_nxt;
    end
  end

  // Divider core: restart beats disable, disable beats counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= C_ONE;
      r_active <= C_RST_HALF;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else if (i_restart || !i_en) begin
      r_cnt    <= C_ONE;
      r_active <= w_shadow_nxt;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else if (w_hit) begin
      r_cnt    <= C_ONE;
      r_active <= w_shadow_nxt;
      r_out    <= ~r_out;
      r_tick   <= ~r_out;
    end else begin
      r_cnt    <= r_cnt + C_ONE;
      r_tick   <= 1'b0;
    end
  end

  assign o_out_clk = r_out;
  assign o_tick    = r_tick;

endmodule : clk_div_channel
`default_nettype wire

// File: rtl/multi_clk_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : multi_clk_div
// Brief   : NUM_CH independent programmable clock dividers sharing one
//           configuration bus and a common restart.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  localparam int unsigned CH_W        = ch_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_half,
  input  logic              i_restart,
  output logic [NUM_CH-1:0] o_out_clk,
  output logic [NUM_CH-1:0] o_tick
);

  // Per-channel write strobe; a select value with no matching channel
  // produces no strobe at all, so out-of-range writes are dropped.
  logic [NUM_CH-1:0] w_ch_we;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch_we[g] = i_cfg_we && (i_cfg_ch == CH_W'(g));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (i_en[g]),
      .i_restart  (i_restart),
      .i_cfg_we   (w_ch_we[g]),
      .i_cfg_half (i_cfg_half),
      .o_out_clk  (o_out_clk[g]),
      .o_tick     (o_tick[g])
    );
  end

endmodule : multi_clk_div
`default_nettype wire

// File: tb/tb_multi_clk_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_multi_clk_div
// Brief   : Self-checking bench for multi_clk_div (directed table, corner
//           sequences, randomized traffic against a countdown model).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multi_clk_div;

  localparam int NUM_CH = 2;
  localparam int DEF    = 25000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        en;
  logic              cfg_we;
  logic [0:0]        cfg_ch;
  logic [15:0]       cfg_half;
  logic              restart;
  logic [1:0]        out_clk;
  logic [1:0]        tick;

  // Second instance with three channels so a select value of 3 is encodable
  logic [2:0]        en3;
  logic              cfg_we3;
  logic [1:0]        cfg_ch3;
  logic [15:0]       cfg_half3;
  logic              restart3;
  logic [2:0]        out3;
  logic [2:0]        tick3;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  multi_clk_div #(.NUM_CH(2), .CNT_W(16), .DEFAULT_HALF(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
    .i_cfg_half(cfg_half), .i_restart(restart), .o_out_clk(out_clk), .o_tick(tick)
  );

  multi_clk_div #(.NUM_CH(3), .CNT_W(16), .DEFAULT_HALF(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_en(en3), .i_cfg_we(cfg_we3), .i_cfg_ch(cfg_ch3),
    .i_cfg_half(cfg_half3), .i_restart(restart3), .o_out_clk(out3), .o_tick(tick3)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model: each channel counts down the cycles left in its current
  // half-period; reaching zero flips the level and reloads from the latest
  // configured value (0 treated as 1).
  int         m_shadow [NUM_CH];
  int         m_rem    [NUM_CH];
  logic [1:0] m_lvl;
  logic [1:0] m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] <= DEF;
        m_rem[i]    <= DEF;
        m_lvl[i]    <= 1'b0;
        m_tick[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int sh;
        int left;
        sh = (cfg_we && int'(cfg_ch) == i) ? int'(cfg_half) : m_shadow[i];
        m_shadow[i] <= sh;
        if (restart || !en[i]) begin
          m_lvl[i]  <= 1'b0;
          m_tick[i] <= 1'b0;
          m_rem[i]  <= (sh < 1) ? 1 : sh;
        end else begin
          left = m_rem[i] - 1;
          if (left == 0) begin
            m_lvl[i]  <= ~m_lvl[i];
            m_tick[i] <= (m_lvl[i] == 1'b0);
            m_rem[i]  <= (sh < 1) ? 1 : sh;
          end else begin
            m_rem[i]  <= left;
            m_tick[i] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model out_clk", {30'd0, out_clk}, {30'd0, m_lvl});
      check("model tick", {30'd0, tick}, {30'd0, m_tick});
    end
  end

  // Edge-position recorder for the directed sequences
  int qc0[$], qc1[$], qt0[$], qt1[$];
  logic [1:0] prev_out;

  task automatic clear_q();
    qc0.delete(); qc1.delete(); qt0.delete(); qt1.delete();
    prev_out = out_clk;
  endtask

  task automatic rec_step(input int e);
    step();
    if (out_clk[0] != prev_out[0]) qc0.push_back(e);
    if (out_clk[1] != prev_out[1]) qc1.push_back(e);
    if (tick[0]) qt0.push_back(e);
    if (tick[1]) qt1.push_back(e);
    prev_out = out_clk;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  typedef struct {
    logic [1:0]  en;
    logic        we;
    logic        ch;
    logic [15:0] half;
    logic        rs;
    logic [1:0]  xo;
    logic [1:0]  xt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    bit found;
    int ft [3];
    int e0 [4];
    int e1 [4];

    // {en, we, ch, half, restart, expected out_clk, expected tick}
    tbl[0]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b01, 2'b01};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 16'd1, 1'b0, 2'b11, 2'b10};
    tbl[3]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b10, 2'b00};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b01};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};
    tbl[6]  = '{2'b11, 1'b1, 1'b0, 16'd0, 1'b0, 2'b01, 2'b01};
    tbl[7]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};
    tbl[8]  = '{2'b10, 1'b0, 1'b0, 16'd0, 1'b0, 2'b10, 2'b10};
    tbl[9]  = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b01};
    tbl[10] = '{2'b11, 1'b1, 1'b1, 16'd2, 1'b1, 2'b00, 2'b00};
    tbl[11] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b01, 2'b01};
    tbl[12] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b10, 2'b10};
    tbl[13] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b11, 2'b01};
    tbl[14] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b00};

    rst_n = 1'b0; en = 2'b00; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_half = 16'd0; restart = 1'b0;
    en3 = 3'b000; cfg_we3 = 1'b0; cfg_ch3 = 2'd0; cfg_half3 = 16'd0; restart3 = 1'b0;
    repeat (3) step();
    check("reset out_clk", {30'd0, out_clk}, 32'd0);
    check("reset tick", {30'd0, tick}, 32'd0);

    // Defaults after reset release: half-period 25000
    rst_n = 1'b1; en = 2'b11; chk_en = 1'b1;
    n = -1; found = 1'b0;
    for (int k = 1; k <= 30000 && !found; k++) begin
      step();
      if (tick[0]) begin n = k; found = 1'b1; end
    end
    check("default first tick edge", n, 25000);
    check("default ch1 tick with ch0", {31'd0, tick[1]}, 32'd1);
    m = -1; found = 1'b0;
    for (int k = n + 1; k <= 60000 && !found; k++) begin
      step();
      if (!out_clk[0]) begin m = k; found = 1'b1; end
    end
    check("default first fall edge", m, 50000);

    // Mid-period write does not disturb the running half-period
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_half = 16'd10; step();
    cfg_ch = 1'b1; cfg_half = 16'd6; step();
    cfg_we = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    check("restart clears out_clk", {30'd0, out_clk}, 32'd0);
    clear_q();
    for (int e = 1; e <= 26; e++) begin
      if (e == 4) begin cfg_we = 1'b1; cfg_ch = 1'b0; cfg_half = 16'd4; end
      rec_step(e);
      cfg_we = 1'b0;
    end
    e0 = '{10, 14, 18, 22};
    e1 = '{6, 12, 18, 24};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midwrite ch0 toggle %0d", i), qat(qc0, i), e0[i]);
      check($sformatf("midwrite ch1 toggle %0d", i), qat(qc1, i), e1[i]);
    end

    // Write landing exactly in the toggle cycle takes effect immediately
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_half = 16'd5; step();
    cfg_we = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    clear_q();
    for (int e = 1; e <= 11; e++) begin
      if (e == 5) begin cfg_we = 1'b1; cfg_ch = 1'b1; cfg_half = 16'd3; end
      rec_step(e);
      cfg_we = 1'b0;
    end
    check("toggle-cycle write ch1 edge 0", qat(qc1, 0), 5);
    check("toggle-cycle write ch1 edge 1", qat(qc1, 1), 8);
    check("toggle-cycle write ch1 edge 2", qat(qc1, 2), 11);

    // Restart realigns channels at half 3 and 5
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_half = 16'd3; step();
    cfg_ch = 1'b1; cfg_half = 16'd5; step();
    cfg_we = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    check("restart out_clk low", {30'd0, out_clk}, 32'd0);
    check("restart tick low", {30'd0, tick}, 32'd0);
    clear_q();
    for (int e = 1; e <= 16; e++) rec_step(e);
    check("restart ch0 tick 0", qat(qt0, 0), 3);
    check("restart ch0 tick 1", qat(qt0, 1), 9);
    check("restart ch0 tick 2", qat(qt0, 2), 15);
    check("restart ch1 tick 0", qat(qt1, 0), 5);
    check("restart ch1 tick 1", qat(qt1, 1), 15);

    // Asynchronous reset between edges, then enable sequencing
    check("pre-reset ch0 level high", {31'd0, out_clk[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async reset out_clk", {30'd0, out_clk}, 32'd0);
    check("async reset tick", {30'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; en = 2'b10;
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_half = 16'd7; step();
    cfg_we = 1'b0; step(); step();
    en = 2'b11;
    clear_q();
    for (int e = 1; e <= 10; e++) rec_step(e);
    check("enable first tick ch0", qat(qt0, 0), 7);

    // Out-of-range select on the three-channel instance is ignored
    en3 = 3'b111; cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_half3 = 16'd1; restart3 = 1'b1;
    step();
    cfg_we3 = 1'b0; restart3 = 1'b0;
    ft = '{-1, -1, -1};
    for (int e = 1; e <= 6; e++) begin
      step();
      for (int c = 0; c < 3; c++) if (tick3[c] && ft[c] < 0) ft[c] = e;
    end
    for (int c = 0; c < 3; c++) check($sformatf("bad select ch%0d first tick", c), ft[c], 4);
    cfg_we3 = 1'b1; cfg_ch3 = 2'd2; cfg_half3 = 16'd2; restart3 = 1'b1;
    step();
    cfg_we3 = 1'b0; restart3 = 1'b0;
    ft = '{-1, -1, -1};
    for (int e = 1; e <= 6; e++) begin
      step();
      for (int c = 0; c < 3; c++) if (tick3[c] && ft[c] < 0) ft[c] = e;
    end
    check("good select ch2 first tick", ft[2], 2);
    check("good select ch0 first tick", ft[0], 4);

    // Table-driven vectors from a disabled state with shadows 2 and 3
    en = 2'b00; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_half = 16'd2; step();
    cfg_ch = 1'b1; cfg_half = 16'd3; step();
    cfg_we = 1'b0; step();
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; cfg_we = tbl[i].we; cfg_ch = tbl[i].ch;
      cfg_half = tbl[i].half; restart = tbl[i].rs;
      step();
      check($sformatf("table row %0d out_clk", i), {30'd0, out_clk}, {30'd0, tbl[i].xo});
      check($sformatf("table row %0d tick", i), {30'd0, tick}, {30'd0, tbl[i].xt});
    end
    cfg_we = 1'b0; restart = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 1'($urandom);
      cfg_half = 16'($urandom_range(0, 6));
      restart  = ($urandom_range(0, 40) == 0);
      step();
    end
    cfg_we = 1'b0; restart = 1'b0;
    step();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multi_clk_div
`default_nettype wire
